// File: rtl/led_al422_pkg.sv
// Shared definitions for the AL422 frame path: writer FSM states and the panel
// geometry that sets how many bytes make up one frame.
package led_al422_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_WRITE,
    ST_PAD,
    ST_TAIL
  } wr_state_t;

  // The LED read side derives its frame length from the same geometry.
  localparam int PANEL_PIXELS        = 8;
  localparam int SCAN_ROWS           = 8;
  localparam int BYTES_PER_PIXEL     = 3;
  localparam int DEFAULT_FRAME_BYTES = PANEL_PIXELS * SCAN_ROWS * BYTES_PER_PIXEL;

endpackage

// File: rtl/al422_frame_writer.sv
// Write-side front end for the AL422 frame FIFO: WRST per frame, one frame of bytes, length policing.
// Optional zero-padding of truncated frames is enabled by defining AL422_SHORT_FRAME_PAD_EN.
module al422_frame_writer
  import led_al422_pkg::*;
#(
  parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES,
  parameter int WRST_CYCLES = 4,
  parameter int CNT_W       = $clog2(FRAME_BYTES + 1)
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_sof,
  output logic       s_ready,
  output logic [7:0] al422_wdata,
  output logic       al422_we_n,
  output logic       al422_wrst_n,
  output logic       frame_done,
  output logic       err_short,
  output logic       err_long,
  output logic       busy
);

  localparam int TMR_W = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(WRST_CYCLES - 1);

  wr_state_t        state, state_nx;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMR_W-1:0] wrst_tmr;
  logic             long_seen;
  logic             accept, short_hit, last_hit, long_hit;

  // A sof beat is held off whenever it would start a new frame, so it stays pending.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_IDLE, ST_TAIL: s_ready = ~(s_valid & s_sof);
      ST_WRITE:         s_ready = ~(s_valid & s_sof & (byte_cnt != '0));
      default:          s_ready = 1'b0;
    endcase
  end

  assign accept    = s_valid & s_ready;
  assign short_hit = (state == ST_WRITE) & s_valid & s_sof & (byte_cnt != '0);
  assign last_hit  = (state == ST_WRITE) & accept & (byte_cnt == LAST_BYTE);
  assign long_hit  = (state == ST_TAIL) & s_valid & ~s_sof & ~long_seen;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_TAIL: if (s_valid & s_sof) state_nx = ST_RST;
      ST_RST:           if (wrst_tmr == TMR_LAST) state_nx = ST_WRITE;
      ST_WRITE: begin
        if (last_hit) begin
          state_nx = ST_TAIL;
        end else if (short_hit) begin
`ifdef AL422_SHORT_FRAME_PAD_EN
          state_nx = ST_PAD;
`else
          state_nx = ST_RST;
`endif
        end
      end
`ifdef AL422_SHORT_FRAME_PAD_EN
      ST_PAD:           if (byte_cnt == LAST_BYTE) state_nx = ST_RST;
`endif
      default:          state_nx = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so WRST and WE never overlap.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      wrst_tmr     <= '0;
      long_seen    <= 1'b0;
      al422_wdata  <= 8'h00;
      al422_we_n   <= 1'b1;
      al422_wrst_n <= 1'b1;
      frame_done   <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      wrst_tmr     <= (state == ST_RST) ? wrst_tmr + TMR_W'(1) : '0;
      al422_wrst_n <= (state_nx != ST_RST);
      busy         <= (state_nx == ST_RST) | (state_nx == ST_WRITE) | (state_nx == ST_PAD);
      frame_done   <= last_hit;
      err_short    <= short_hit;
      err_long     <= long_hit;
      al422_we_n   <= 1'b1;

      if (state == ST_RST) begin
        long_seen <= 1'b0;
      end else if (long_hit) begin
        long_seen <= 1'b1;
      end

      case (state)
        ST_RST:   byte_cnt <= '0;
        ST_WRITE: if (accept && byte_cnt != FULL_CNT) byte_cnt <= byte_cnt + CNT_W'(1);
        ST_PAD:   if (byte_cnt != FULL_CNT) byte_cnt <= byte_cnt + CNT_W'(1);
        default:  byte_cnt <= byte_cnt;
      endcase

      if (state == ST_WRITE && accept) begin
        al422_we_n  <= 1'b0;
        al422_wdata <= s_data;
      end
`ifdef AL422_SHORT_FRAME_PAD_EN
      if (state_nx == ST_PAD) begin
        al422_we_n  <= 1'b0;
        al422_wdata <= 8'h00;
      end
`endif
    end
  end

endmodule
